ring_decoder: RTL and testbench

//   Receive side of the one-hot ring counter bus. Samples an 8-bit one-hot ring pattern
//   and decodes it to a binary index. Checks each step against the ring's right-rotate

---
 rtl/ring_decoder.sv | 146 ++++++++++++++
 tb/tb_ring_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// Receive-side decoder for the one-hot ring counter bus: decodes the set bit to an
// index, tracks right-rotate ordering, locks onto a valid sequence and counts revolutions.
module ring_decoder #(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 3,
    parameter int LOCK_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_valid,
    input  logic             clr_cnt,
    output logic [IDX_W-1:0] index,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] rev_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] expected_q, expected_d;
    logic [IDX_W-1:0] good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             illegal_q, illegal_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] rev_count_q, rev_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             legal;
    logic             match;
    logic [IDX_W-1:0] k;
    logic             rev_inc;
    logic             err_inc;

    // A power-of-two pattern has exactly one bit set: clearing its lowest set bit leaves zero.
    assign legal = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
    assign match = legal && (k == expected_q);

    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) k = IDX_W'(i);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        expected_d = expected_q;
        good_cnt_d = good_cnt_q;
        index_d    = index_q;
        illegal_d  = 1'b0;
        seq_err_d  = 1'b0;
        rev_inc    = 1'b0;
        err_inc    = 1'b0;

        if (ring_valid) begin
            if (legal) begin
                index_d    = k;
                // WIDTH == 2**IDX_W, so the subtraction wraps 0 to WIDTH-1 for free.
                expected_d = k - IDX_W'(1);
            end else begin
                illegal_d = 1'b1;
            end

            case (state_q)
                HUNT: begin
                    if (legal) begin
                        state_d    = VERIFY;
                        good_cnt_d = IDX_W'(1);
                    end
                end
                VERIFY: begin
                    if (match) begin
                        good_cnt_d = good_cnt_q + IDX_W'(1);
                        if (good_cnt_q + IDX_W'(1) == IDX_W'(LOCK_N)) state_d = LOCKED;
                    end else if (legal) begin
                        good_cnt_d = IDX_W'(1);
                    end else begin
                        state_d    = HUNT;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        rev_inc = (k == '0);
                    end else begin
                        state_d    = HUNT;
                        good_cnt_d = '0;
                        seq_err_d  = 1'b1;
                        err_inc    = 1'b1;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    good_cnt_d = '0;
                end
            endcase
        end

        if (clr_cnt) begin
            rev_count_d = '0;
            err_count_d = '0;
        end else begin
            rev_count_d = rev_inc ? rev_count_q + CNT_W'(1) : rev_count_q;
            err_count_d = (err_inc && err_count_q != '1) ? err_count_q + CNT_W'(1) : err_count_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            good_cnt_q  <= '0;
            index_q     <= '0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            rev_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_cnt_q  <= good_cnt_d;
            index_q     <= index_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            rev_count_q <= rev_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign index     = index_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == LOCKED);
    assign rev_count = rev_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed vector table, hand-written corner sequences and a
// randomized run against a chain-length reference model; a CNT_W=2 copy covers counter limits.
module tb_ring_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] ring_in;
    logic       ring_valid;
    logic       clr_cnt;

    logic [2:0] index1, index2;
    logic       illegal1, illegal2, seq_err1, seq_err2, locked1, locked2;
    logic [7:0] rev1, err1;
    logic [1:0] rev2, err2;

    int n_checks = 0;
    int n_errors = 0;

    ring_decoder #(.WIDTH(8), .IDX_W(3), .LOCK_N(3), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .ring_in(ring_in), .ring_valid(ring_valid),
        .clr_cnt(clr_cnt), .index(index1), .illegal(illegal1), .seq_err(seq_err1),
        .locked(locked1), .rev_count(rev1), .err_count(err1)
    );

    ring_decoder #(.WIDTH(8), .IDX_W(3), .LOCK_N(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .ring_in(ring_in), .ring_valid(ring_valid),
        .clr_cnt(clr_cnt), .index(index2), .illegal(illegal2), .seq_err(seq_err2),
        .locked(locked2), .rev_count(rev2), .err_count(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] ring;
        logic       clr;
        logic [2:0] idx;
        logic       ill;
        logic       seq;
        logic       lck;
        logic [7:0] rev;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] ring, input logic clr,
                                input logic [2:0] idx, input logic ill, input logic seq,
                                input logic lck, input logic [7:0] rev, input logic [7:0] err);
        vec_t t;
        t.v = v; t.ring = ring; t.clr = clr; t.idx = idx; t.ill = ill;
        t.seq = seq; t.lck = lck; t.rev = rev; t.err = err;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] r, input logic c);
        ring_valid = v;
        ring_in    = r;
        clr_cnt    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ring_valid = 1'b0;
        ring_in    = 8'h00;
        clr_cnt    = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: tracks the length of the current in-order chain and whether it is locked.
    int m_idx, m_exp, m_chain, m_rev, m_err, m_rev2, m_err2;
    bit m_locked, m_ill, m_seq;

    task automatic model_reset();
        m_idx = 0; m_exp = 0; m_chain = 0; m_rev = 0; m_err = 0; m_rev2 = 0; m_err2 = 0;
        m_locked = 0; m_ill = 0; m_seq = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] r, input logic c);
        int  kk;
        bit  is_match, brk, rev_inc;
        m_ill = 0; m_seq = 0; brk = 0; rev_inc = 0; kk = 0;
        if (v) begin
            if ($countones(r) == 1) begin
                for (int i = 0; i < 8; i++) if (r[i]) kk = i;
                is_match = (kk == m_exp);
                m_idx = kk;
                m_exp = (kk + 7) % 8;
                if (m_locked) begin
                    if (is_match) rev_inc = (kk == 0);
                    else brk = 1;
                end else if (m_chain == 0) begin
                    m_chain = 1;
                end else if (is_match) begin
                    m_chain++;
                    if (m_chain == 3) m_locked = 1;
                end else begin
                    m_chain = 1;
                end
            end else begin
                m_ill = 1;
                if (m_locked) brk = 1;
                else m_chain = 0;
            end
        end
        if (brk) begin
            m_locked = 0; m_chain = 0; m_seq = 1;
        end
        if (c) begin
            m_rev = 0; m_err = 0; m_rev2 = 0; m_err2 = 0;
        end else begin
            if (rev_inc) begin
                m_rev  = (m_rev + 1) % 256;
                m_rev2 = (m_rev2 + 1) % 4;
            end
            if (brk) begin
                if (m_err < 255) m_err++;
                if (m_err2 < 3) m_err2++;
            end
        end
    endtask

    initial begin
        logic       v, c;
        logic [7:0] r;
        int         sel;

        // Lock, two revolutions, break, illegal, relock, gap, clear on wrap.
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h80, 0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h40, 0, 6, 0, 0, 1, 0, 0));
        for (int b = 5; b >= 1; b--) tbl.push_back(mk(1, 8'(1 << b), 0, 3'(b), 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 1, 1, 0));
        for (int b = 7; b >= 1; b--) tbl.push_back(mk(1, 8'(1 << b), 0, 3'(b), 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 1, 2, 0));
        for (int b = 7; b >= 4; b--) tbl.push_back(mk(1, 8'(1 << b), 0, 3'(b), 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 8'h40, 0, 6, 0, 1, 0, 2, 1));
        tbl.push_back(mk(1, 8'h03, 0, 6, 1, 0, 0, 2, 1));
        tbl.push_back(mk(1, 8'h10, 0, 4, 0, 0, 0, 2, 1));
        tbl.push_back(mk(1, 8'h08, 0, 3, 0, 0, 0, 2, 1));
        tbl.push_back(mk(1, 8'h04, 0, 2, 0, 0, 1, 2, 1));
        for (int g = 0; g < 5; g++) tbl.push_back(mk(0, 8'hFF, 0, 2, 0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 8'h02, 0, 1, 0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 8'h01, 1, 0, 0, 0, 1, 0, 0));

        do_reset();
        check("reset.index", 32'(index1), 0);
        check("reset.illegal", 32'(illegal1), 0);
        check("reset.seq_err", 32'(seq_err1), 0);
        check("reset.locked", 32'(locked1), 0);
        check("reset.rev", 32'(rev1), 0);
        check("reset.err", 32'(err1), 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].ring, tbl[i].clr);
            check($sformatf("tbl%0d.index", i), 32'(index1), 32'(tbl[i].idx));
            check($sformatf("tbl%0d.illegal", i), 32'(illegal1), 32'(tbl[i].ill));
            check($sformatf("tbl%0d.seq_err", i), 32'(seq_err1), 32'(tbl[i].seq));
            check($sformatf("tbl%0d.locked", i), 32'(locked1), 32'(tbl[i].lck));
            check($sformatf("tbl%0d.rev", i), 32'(rev1), 32'(tbl[i].rev));
            check($sformatf("tbl%0d.err", i), 32'(err1), 32'(tbl[i].err));
        end

        // Counter limits on the CNT_W=2 instance.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            step(1, 8'h01, 0); step(1, 8'h80, 0); step(1, 8'h40, 0);
            check($sformatf("sat%0d.locked", n), 32'(locked2), 1);
            step(1, 8'h01, 0);
            check($sformatf("sat%0d.seq_err", n), 32'(seq_err2), 1);
            check($sformatf("sat%0d.err", n), 32'(err2), (n + 1 > 3) ? 3 : n + 1);
        end
        step(1, 8'h01, 0); step(1, 8'h80, 0); step(1, 8'h40, 0);
        check("wrap.lock_rev", 32'(rev2), 0);
        for (int b = 5; b >= 1; b--) step(1, 8'(1 << b), 0);
        step(1, 8'h01, 0);
        check("wrap.rev1", 32'(rev2), 1);
        for (int n = 2; n <= 4; n++) begin
            for (int b = 7; b >= 1; b--) step(1, 8'(1 << b), 0);
            step(1, 8'h01, 0);
            check($sformatf("wrap.rev%0d", n), 32'(rev2), n % 4);
        end
        check("wrap.err_held", 32'(err2), 3);

        // Asynchronous reset between edges while locked.
        do_reset();
        step(1, 8'h01, 0); step(1, 8'h80, 0); step(1, 8'h40, 0);
        for (int b = 5; b >= 1; b--) step(1, 8'(1 << b), 0);
        step(1, 8'h01, 0);
        check("arst.pre_rev", 32'(rev1), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst.index", 32'(index1), 0);
        check("arst.locked", 32'(locked1), 0);
        check("arst.rev", 32'(rev1), 0);
        check("arst.err", 32'(err1), 0);
        check("arst.illegal", 32'(illegal1), 0);
        check("arst.seq_err", 32'(seq_err1), 0);
        #1;
        reset = 1'b0;
        step(1, 8'h00, 0);
        check("arst.zero_illegal", 32'(illegal1), 1);
        check("arst.zero_locked", 32'(locked1), 0);
        check("arst.zero_seq_err", 32'(seq_err1), 0);
        step(1, 8'h40, 0);
        step(1, 8'h20, 0);
        check("arst.hunt_verify", 32'(locked1), 0);
        step(1, 8'h10, 0);
        check("arst.relock", 32'(locked1), 1);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v   = ($urandom_range(0, 7) != 0);
            c   = ($urandom_range(0, 49) == 0);
            sel = $urandom_range(0, 99);
            if (sel < 75)      r = 8'(1 << m_exp);
            else if (sel < 85) r = 8'(1 << $urandom_range(0, 7));
            else if (sel < 93) r = 8'($urandom);
            else if (sel < 96) r = 8'h00;
            else               r = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
            model_step(v, r, c);
            step(v, r, c);
            check($sformatf("rnd%0d.index", cyc), 32'(index1), 32'(m_idx));
            check($sformatf("rnd%0d.illegal", cyc), 32'(illegal1), 32'(m_ill));
            check($sformatf("rnd%0d.seq_err", cyc), 32'(seq_err1), 32'(m_seq));
            check($sformatf("rnd%0d.locked", cyc), 32'(locked1), 32'(m_locked));
            check($sformatf("rnd%0d.rev", cyc), 32'(rev1), 32'(m_rev));
            check($sformatf("rnd%0d.err", cyc), 32'(err1), 32'(m_err));
            check($sformatf("rnd%0d.rev2", cyc), 32'(rev2), 32'(m_rev2));
            check($sformatf("rnd%0d.err2", cyc), 32'(err2), 32'(m_err2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
